// File: rtl/axi4stream_row_block_scheduler_pkg.sv
// Shared definitions for the row/block scheduler: FSM state encoding and
// elaboration-time sizing helpers.
package axi4stream_row_block_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_FILL  = 2'd2,
        ST_HOLD  = 2'd3
    } sched_state_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        longint unsigned v;
        r = 0;
        v = 1;
        while (v < longint'(n)) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int unsigned idx_width(input int unsigned n);
        return (clog2(n) == 0) ? 1 : clog2(n);
    endfunction

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/axi4stream_row_block_scheduler_beat_row_counter.sv
// Beat-in-row and row-in-block counters; flags the last beat of a row and
// the last beat of a block.
module axi4stream_row_block_scheduler_beat_row_counter
    import axi4stream_row_block_scheduler_pkg::*;
#(
    parameter  int unsigned BEATS_PER_ROW = 3,
    parameter  int unsigned N_ROWS        = 2,
    localparam int unsigned ROW_W         = idx_width(N_ROWS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             beat_i,
    output logic [ROW_W-1:0] row_o,
    output logic             row_wrap_o,
    output logic             blk_last_o
);
    localparam int unsigned BEAT_W = idx_width(BEATS_PER_ROW);

    logic [BEAT_W-1:0] beat_q;
    logic [ROW_W-1:0]  row_q;

    assign row_wrap_o = (beat_q == BEAT_W'(BEATS_PER_ROW - 1));
    assign blk_last_o = row_wrap_o && (row_q == ROW_W'(N_ROWS - 1));
    assign row_o      = row_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            beat_q <= '0;
            row_q  <= '0;
        end else if (beat_i) begin
            if (row_wrap_o) begin
                beat_q <= '0;
                row_q  <= blk_last_o ? '0 : row_q + ROW_W'(1);
            end else begin
                beat_q <= beat_q + BEAT_W'(1);
            end
        end
    end

endmodule

// File: rtl/axi4stream_row_block_scheduler.sv
// Sequences the stream row buffer: clears it, passes DMA beats through,
// flags each full block and stalls the DMA until the core takes it.
module axi4stream_row_block_scheduler
    import axi4stream_row_block_scheduler_pkg::*;
#(
    parameter  int unsigned AXI_PACKET_SIZE = 8,
    parameter  int unsigned ROW_SIZE        = 20,
    parameter  int unsigned N_ROWS          = 2,
    localparam int unsigned ROW_W           = idx_width(N_ROWS)
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic                       enable,
    input  logic [AXI_PACKET_SIZE-1:0] s_tdata,
    input  logic                       s_tvalid,
    input  logic                       s_tlast,
    output logic                       s_tready,
    output logic [AXI_PACKET_SIZE-1:0] m_tdata,
    output logic                       m_tvalid,
    output logic                       m_tlast,
    input  logic                       m_tready,
    output logic                       buf_clear,
    output logic                       blk_valid,
    input  logic                       blk_ready,
    output logic [ROW_W-1:0]           row_idx,
    output logic [15:0]                blk_count,
    output logic                       err_tlast
);
    localparam int unsigned BEATS_PER_ROW = ceil_div(ROW_SIZE, AXI_PACKET_SIZE);

    sched_state_e state_q;
    logic         buf_clear_q;
    logic         blk_valid_q;
    logic [15:0]  blk_count_q;
    logic         err_tlast_q;
    logic         fill;
    logic         beat_acc;
    logic         row_wrap;
    logic         blk_last;

    // Zero-latency pass-through, gated to the FILL window.
    assign fill     = (state_q == ST_FILL);
    assign beat_acc = fill & s_tvalid & m_tready;
    assign s_tready = fill & m_tready;
    assign m_tvalid = fill & s_tvalid;
    assign m_tdata  = s_tdata;
    assign m_tlast  = fill & row_wrap;

    assign buf_clear = buf_clear_q;
    assign blk_valid = blk_valid_q;
    assign blk_count = blk_count_q;
    assign err_tlast = err_tlast_q;

    axi4stream_row_block_scheduler_beat_row_counter #(
        .BEATS_PER_ROW (BEATS_PER_ROW),
        .N_ROWS        (N_ROWS)
    ) u_cnt (
        .clk_i      (aclk),
        .rst_i      (areset),
        .clr_i      (state_q == ST_CLEAR),
        .beat_i     (beat_acc),
        .row_o      (row_idx),
        .row_wrap_o (row_wrap),
        .blk_last_o (blk_last)
    );

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= ST_IDLE;
            buf_clear_q <= 1'b0;
            blk_valid_q <= 1'b0;
            blk_count_q <= 16'd0;
            err_tlast_q <= 1'b0;
        end else begin
            buf_clear_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        state_q     <= ST_CLEAR;
                        buf_clear_q <= 1'b1;
                    end
                end
                ST_CLEAR: state_q <= ST_FILL;
                ST_FILL: begin
                    // Early tlast gives a short block; a missing tlast still ends it.
                    if (beat_acc) begin
                        if (s_tlast ^ blk_last) err_tlast_q <= 1'b1;
                        if (s_tlast | blk_last) begin
                            state_q     <= ST_HOLD;
                            blk_valid_q <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (blk_ready) begin
                        blk_valid_q <= 1'b0;
                        blk_count_q <= blk_count_q + 16'd1;
                        if (enable) begin
                            state_q     <= ST_CLEAR;
                            buf_clear_q <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
